// File: rtl/clause_sampler.sv
// clause_sampler: drains unsatisfied clauses from the FIFO tree into a local buffer,
// then picks one uniformly at random (LFSR + serial modulo) for the variable-flip stage.
module clause_sampler #(
   parameter int          CLAUSE_WIDTH = 9,
   parameter int          BUF_DEPTH    = 64,
   parameter int          DRAIN_IDLE   = 4,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    fifo_empty,
   input  logic                    fifo_OF,
   input  logic [CLAUSE_WIDTH-1:0] fifo_clause,
   output logic                    fifo_rden,
   output logic                    fifo_cOF,
   output logic [CLAUSE_WIDTH-1:0] sel_clause,
   output logic                    sel_valid,
   input  logic                    sel_ack,
   output logic                    none,
   output logic                    lost,
   output logic                    busy
);

   localparam int              IDX_W      = $clog2(BUF_DEPTH);
   localparam int              IC_W       = $clog2(DRAIN_IDLE + 1);
   localparam logic [15:0]     LFSR_MASK  = 16'hB400;
   localparam logic [IDX_W:0]  FULL_N     = (IDX_W+1)'(BUF_DEPTH);
   localparam logic [IDX_W:0]  ONE_N      = (IDX_W+1)'(1);
   localparam logic [IC_W-1:0] IDLE_LIMIT = IC_W'(DRAIN_IDLE);
   localparam logic [IC_W-1:0] ONE_IC     = IC_W'(1);

   typedef enum logic [2:0] {IDLE, DRAIN, PICK, FETCH, RESULT} state_e;

   state_e                  state_q, state_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [IDX_W:0]          count_q, count_d;
   logic [IC_W-1:0]         idleCnt_q, idleCnt_d;
   logic                    lost_q, lost_d;
   logic                    ofSeen_q, ofSeen_d;
   logic                    rdPend_q, rdPend_d;
   logic                    cof_q, cof_d;
   logic [15:0]             r_q, r_d;
   logic [15:0]             rem_q, rem_d;
   logic [3:0]              bit_q, bit_d;
   logic [CLAUSE_WIDTH-1:0] sel_q, sel_d;
   logic                    wrEn;
   logic [IDX_W-1:0]        wrAddr;
   logic [16:0]             remShift;
   logic [16:0]             remDiff;
   logic [CLAUSE_WIDTH-1:0] clauseBuf_q [BUF_DEPTH];

   // One restoring-division step; bit 16 of the difference is the borrow.
   assign remShift = {rem_q, r_q[bit_q]};
   assign remDiff  = remShift - {{(16-IDX_W){1'b0}}, count_q};

   always_comb begin
      state_d   = state_q;
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      count_d   = count_q;
      idleCnt_d = idleCnt_q;
      lost_d    = lost_q;
      ofSeen_d  = ofSeen_q;
      rdPend_d  = 1'b0;
      cof_d     = 1'b0;
      r_d       = r_q;
      rem_d     = rem_q;
      bit_d     = bit_q;
      sel_d     = sel_q;
      wrEn      = 1'b0;
      wrAddr    = count_q[IDX_W-1:0];
      fifo_rden = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = DRAIN;
               count_d   = '0;
               idleCnt_d = '0;
               lost_d    = 1'b0;
               ofSeen_d  = 1'b0;
            end
         end
         DRAIN: begin
            fifo_rden = !fifo_empty;
            rdPend_d  = !fifo_empty;
            if (rdPend_q) begin
               if (count_q < FULL_N) begin
                  wrEn    = 1'b1;
                  count_d = count_q + ONE_N;
               end else begin
                  lost_d = 1'b1;
               end
            end
            if (fifo_OF) begin
               ofSeen_d = 1'b1;
               lost_d   = 1'b1;
            end
            // A read issued this cycle keeps the count at zero; DRAIN_IDLE >= 2
            // guarantees the last capture lands before the drain ends.
            if (fifo_empty) idleCnt_d = idleCnt_q + ONE_IC;
            else            idleCnt_d = '0;
            if (idleCnt_q == IDLE_LIMIT) begin
               if (count_q == '0) begin
                  state_d = RESULT;
                  cof_d   = ofSeen_d;
               end else begin
                  state_d = PICK;
                  r_d     = lfsr_q;
                  rem_d   = '0;
                  bit_d   = 4'd15;
               end
            end
         end
         PICK: begin
            rem_d = remDiff[16] ? remShift[15:0] : remDiff[15:0];
            bit_d = bit_q - 4'd1;
            if (bit_q == 4'd0) state_d = FETCH;
         end
         FETCH: begin
            sel_d   = clauseBuf_q[rem_q[IDX_W-1:0]];
            state_d = RESULT;
            cof_d   = ofSeen_q;
         end
         RESULT: begin
            if (sel_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         lfsr_q    <= SEED;
         count_q   <= '0;
         idleCnt_q <= '0;
         lost_q    <= 1'b0;
         ofSeen_q  <= 1'b0;
         rdPend_q  <= 1'b0;
         cof_q     <= 1'b0;
         r_q       <= '0;
         rem_q     <= '0;
         bit_q     <= '0;
         sel_q     <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         count_q   <= count_d;
         idleCnt_q <= idleCnt_d;
         lost_q    <= lost_d;
         ofSeen_q  <= ofSeen_d;
         rdPend_q  <= rdPend_d;
         cof_q     <= cof_d;
         r_q       <= r_d;
         rem_q     <= rem_d;
         bit_q     <= bit_d;
         sel_q     <= sel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) clauseBuf_q[wrAddr] <= fifo_clause;
   end

   assign fifo_cOF   = cof_q;
   assign sel_clause = sel_q;
   assign sel_valid  = (state_q == RESULT);
   assign none       = sel_valid && (count_q == '0);
   assign lost       = sel_valid && lost_q;
   assign busy       = (state_q != IDLE);

endmodule
